// File: rtl/sbus_store_arbiter.sv
// S-bus write-back arbiter: grants one requester per cycle, registers its data and a one-hot store strobe.
// Optional feature macro: SBUS_STORE_ARB_RR_EN (round-robin start pointer; fixed priority when undefined).
module sbus_store_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int DST_W   = 3
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DST_W-1:0] dst,
  input  logic [NUM_REQ*16-1:0]    wdata,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [15:0]              S_bus,
  output logic [NUM_REG-1:0]       SR,
  output logic                     err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: req is the valid, gnt is the ready. A request transfers on the
  // rising edge where req[i] && gnt[i]; until then req/dst/wdata must stay stable.
  logic [PTR_W-1:0]   start;
  logic               grant_en;
  logic               found;
  logic               any_gnt;
  logic [DST_W-1:0]   sel_dst;
  logic [15:0]        sel_wdata;
  logic [NUM_REG-1:0] sr_next;
  logic               dst_bad;

  assign grant_en = CLR && !hold;
  assign any_gnt  = |gnt;

  // Two passes give the wrapped search order start..N-1 then 0..start-1.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    if (grant_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i >= int'(start))) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_dst   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_dst   = dst[i*DST_W +: DST_W];
        sel_wdata = wdata[i*16 +: 16];
      end
    end
  end

  // Out-of-range indices decode to no strobe at all.
  always_comb begin
    sr_next = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      sr_next[r] = (int'(sel_dst) == r);
    end
  end

  assign dst_bad = (int'(sel_dst) >= NUM_REG);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      S_bus <= '0;
      SR    <= '0;
      err   <= 1'b0;
    end else begin
      SR <= '0;
      if (any_gnt) begin
        S_bus <= sel_wdata;
        SR    <= sr_next;
        if (dst_bad) begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef SBUS_STORE_ARB_RR_EN
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;

  // Pointer moves just past the winner; idle or held cycles leave it alone.
  always_comb begin
    ptr_next = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

endmodule

// File: tb/tb_sbus_store_arbiter.sv
// Self-checking bench for sbus_store_arbiter (NUM_REQ=4, NUM_REG=6 so out-of-range indices exist).
// Follows SBUS_STORE_ARB_RR_EN for the expected arbitration order.
module tb_sbus_store_arbiter;

  localparam int NQ = 4;
  localparam int NR = 6;
  localparam int DW = 3;
  localparam int BW = 16 + NR + 1;

  logic           clk;
  logic           clr;
  logic [NQ-1:0]  req;
  logic [NQ*DW-1:0] dst;
  logic [NQ*16-1:0] wdata;
  logic           hold;
  logic [NQ-1:0]  gnt;
  logic [15:0]    s_bus;
  logic [NR-1:0]  sr;
  logic           err;

  sbus_store_arbiter #(.NUM_REQ(NQ), .NUM_REG(NR), .DST_W(DW)) dut (
    .CLK   (clk),
    .CLR   (clr),
    .req   (req),
    .dst   (dst),
    .wdata (wdata),
    .hold  (hold),
    .gnt   (gnt),
    .S_bus (s_bus),
    .SR    (sr),
    .err   (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_ptr;
  logic [15:0] m_sbus;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_sbus = '0;
    m_err  = 1'b0;
  endtask

  function automatic logic [NQ-1:0] model_gnt();
    int idx;
    if (!clr || hold) return '0;
    for (int off = 0; off < NQ; off++) begin
      idx = (m_ptr + off) % NQ;
      if (req[idx]) return NQ'(1) << idx;
    end
    return '0;
  endfunction

  // driver: one cycle from a negedge to the next; inputs are already set by the caller
  task automatic tick();
    logic [NQ-1:0] eg;
    logic [NR-1:0] esr;
    logic [DW-1:0] d;
    logic [BW-1:0] beat;
    int k;
    #1;
    eg = model_gnt();
    check("gnt", 32'(gnt), 32'(eg));
    k = -1;
    for (int i = 0; i < NQ; i++) if (eg[i]) k = i;
    esr = '0;
    if (!clr) begin
      model_reset();
    end else if (k >= 0) begin
      d = dst[k*DW +: DW];
      m_sbus = wdata[k*16 +: 16];
      if (int'(d) < NR) esr = NR'(1) << d;
      else m_err = 1'b1;
`ifdef SBUS_STORE_ARB_RR_EN
      m_ptr = (k + 1) % NQ;
`endif
    end
    exp_q.push_back({m_sbus, esr, m_err});
    @(posedge clk);
    @(negedge clk);
    beat = exp_q.pop_front();
    check("s_bus", 32'(s_bus), 32'(beat[BW-1 -: 16]));
    check("sr", 32'(sr), 32'(beat[NR:1]));
    check("err", 32'(err), 32'(beat[0]));
  endtask

  task automatic set_src(input int k, input logic [DW-1:0] d, input logic [15:0] w);
    dst[k*DW +: DW] = d;
    wdata[k*16 +: 16] = w;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    req = '0;
    tick();
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; req = '0; dst = '0; wdata = '0; hold = 1'b0;
    model_reset();

    // reset state with every requester active
    req = 4'b1111;
    for (int i = 0; i < NQ; i++) set_src(i, DW'(i), 16'h1000 + 16'(i));
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sr", 32'(sr), 32'h0);
    check("rst_sbus", 32'(s_bus), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    clr = 1'b1;
    tick();
    req = '0;
    tick();

    // single write to register 5
    set_src(2, 3'd5, 16'hBEEF);
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();

    // round robin (or fixed priority) with all four requesting
    do_reset();
    for (int i = 0; i < NQ; i++) set_src(i, DW'(i), 16'hA000 + 16'(i));
    req = 4'b1111;
    repeat (5) tick();
    req = '0;
    tick();

    // hold suppresses grants, then the held request goes through
    set_src(1, 3'd2, 16'h1234);
    req = 4'b0010;
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    tick();
    req = '0;
    tick();

    // out-of-range index sets sticky err; next valid write still pulses
    set_src(0, 3'd7, 16'hDEAD);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    set_src(3, 3'd4, 16'hC0DE);
    req = 4'b1000;
    tick();
    req = '0;
    tick();

    // reset asserted while an SR pulse is on the outputs
    set_src(2, 3'd3, 16'h5A5A);
    req = 4'b0100;
    tick();
    req = '0;
    clr = 1'b0;
    #1;
    check("mid_sr", 32'(sr), 32'h0);
    check("mid_sbus", 32'(s_bus), 32'h0);
    check("mid_err", 32'(err), 32'h0);
    model_reset();
    tick();
    clr = 1'b1;
    req = 4'b1111;
    tick();
    req = '0;
    tick();

    // random traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NQ; i++) set_src(i, DW'($urandom_range(0, 7)), 16'($urandom));
      req  = NQ'($urandom_range(0, 15));
      hold = ($urandom_range(0, 4) == 0);
      tick();
    end
    req = '0;
    hold = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
